// File: rtl/minmax_pkg.sv
// Shared types and width helpers for the streaming min/max tracker.
package minmax_pkg;

    typedef enum logic [1:0] {
        FIRST,
        ACCUM,
        HOLD
    } state_t;

    // Index outputs keep at least one bit even for single-sample frames.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cmp_n.sv
// Combinational unsigned magnitude compare: gt = a > b, lt = a < b.
module cmp_n #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Streaming unsigned min/max tracker: one registered result per frame,
// reporting the first index at which the max and min occurred.
module minmax_tracker
    import minmax_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int FRAME_LEN = 8,
    localparam int IDX_W     = idx_width(FRAME_LEN),
    localparam int CNT_W     = cnt_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_count
);

    state_t           state, next_state;
    logic [CNT_W-1:0] count, nxt_count;
    logic [WIDTH-1:0] cur_max, cur_min, nxt_max, nxt_min;
    logic [IDX_W-1:0] cur_max_idx, cur_min_idx, nxt_max_idx, nxt_min_idx;
    logic             take, frame_done;
    logic             gt_max, lt_max, gt_min, lt_min;
    logic             new_max, new_min;

    cmp_n #(.WIDTH(WIDTH)) u_cmp_max (
        .a  (in_data),
        .b  (cur_max),
        .gt (gt_max),
        .lt (lt_max)
    );

    cmp_n #(.WIDTH(WIDTH)) u_cmp_min (
        .a  (in_data),
        .b  (cur_min),
        .gt (gt_min),
        .lt (lt_min)
    );

    // Strict compares only, so a tie keeps the earlier index.
    assign new_max = gt_max && !lt_max;
    assign new_min = lt_min && !gt_min;

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign take      = in_valid && in_ready;

    always_comb begin
        next_state  = state;
        nxt_count   = count;
        nxt_max     = cur_max;
        nxt_min     = cur_min;
        nxt_max_idx = cur_max_idx;
        nxt_min_idx = cur_min_idx;
        frame_done  = 1'b0;
        unique case (state)
            FIRST: begin
                if (take) begin
                    nxt_max     = in_data;
                    nxt_min     = in_data;
                    nxt_max_idx = '0;
                    nxt_min_idx = '0;
                    nxt_count   = CNT_W'(1);
                    frame_done  = in_last || (FRAME_LEN == 1);
                    next_state  = frame_done ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (take) begin
                    if (new_max) begin
                        nxt_max     = in_data;
                        nxt_max_idx = IDX_W'(count);
                    end
                    if (new_min) begin
                        nxt_min     = in_data;
                        nxt_min_idx = IDX_W'(count);
                    end
                    nxt_count  = count + 1'b1;
                    frame_done = in_last || (nxt_count == CNT_W'(FRAME_LEN));
                    if (frame_done) begin
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    next_state = FIRST;
                    nxt_count  = '0;
                end
            end
            default: next_state = FIRST;
        endcase
    end

    // Result registers load only on the closing sample, so they keep the
    // previous frame's values while the next frame accumulates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FIRST;
            count       <= '0;
            cur_max     <= '0;
            cur_min     <= '0;
            cur_max_idx <= '0;
            cur_min_idx <= '0;
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= '0;
            out_min_idx <= '0;
            out_count   <= '0;
        end else begin
            state       <= next_state;
            count       <= nxt_count;
            cur_max     <= nxt_max;
            cur_min     <= nxt_min;
            cur_max_idx <= nxt_max_idx;
            cur_min_idx <= nxt_min_idx;
            if (frame_done) begin
                out_max     <= nxt_max;
                out_min     <= nxt_min;
                out_max_idx <= nxt_max_idx;
                out_min_idx <= nxt_min_idx;
                out_count   <= nxt_count;
            end
        end
    end

endmodule
